host_output_scheduler: RTL and testbench

//   Per-class descriptor scheduler in front of host_tx. Buffers 13-bit pkt descriptors
//   {inport[3:0], bufid[8:0]} from TS, RC and BE requesters in three FIFOs. Issues one

---
 rtl/host_output_scheduler_pkg.sv | 9 +
 rtl/host_output_scheduler_if.sv | 26 ++
 rtl/host_output_scheduler_fifo.sv | 43 ++++
 rtl/host_output_scheduler.sv | 67 ++++++
 tb/tb_host_output_scheduler.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/host_output_scheduler_pkg.sv
// hos_pkg: shared descriptor width, class indices and FSM encodings for the host output scheduler
package hos_pkg;
  localparam int DESC_W = 13;
  localparam int TS = 0;
  localparam int RC = 1;
  localparam int BE = 2;
  typedef logic [DESC_W-1:0] desc_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} hos_state_e;
endpackage

// File: rtl/host_output_scheduler_if.sv
// hos_if: requester write ports and host_tx issue handshake of the scheduler
interface hos_if;
  import hos_pkg::*;
  desc_t iv_ts_descriptor;
  logic i_ts_descriptor_wr;
  desc_t iv_rc_descriptor;
  logic i_rc_descriptor_wr;
  desc_t iv_be_descriptor;
  logic i_be_descriptor_wr;
  logic i_pkt_descriptor_ready;
  desc_t ov_pkt_descriptor;
  logic o_pkt_descriptor_wr;
  logic [2:0] ov_overflow_pulse;
  logic [2:0] ov_queue_empty;
  logic [1:0] hos_state;
  modport slave (
    input iv_ts_descriptor, i_ts_descriptor_wr, iv_rc_descriptor, i_rc_descriptor_wr,
    input iv_be_descriptor, i_be_descriptor_wr, i_pkt_descriptor_ready,
    output ov_pkt_descriptor, o_pkt_descriptor_wr, ov_overflow_pulse, ov_queue_empty, hos_state
  );
  modport master (
    output iv_ts_descriptor, i_ts_descriptor_wr, iv_rc_descriptor, i_rc_descriptor_wr,
    output iv_be_descriptor, i_be_descriptor_wr, i_pkt_descriptor_ready,
    input ov_pkt_descriptor, o_pkt_descriptor_wr, ov_overflow_pulse, ov_queue_empty, hos_state
  );
endinterface

// File: rtl/host_output_scheduler_fifo.sv
// host_desc_fifo: DEPTH x descriptor FIFO with registered count/empty and a one-cycle drop pulse
module host_desc_fifo
  import hos_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_i,
  input  desc_t din_i,
  input  logic  pop_i,
  output desc_t head_o,
  output logic  empty_o,
  output logic  drop_o
);
  localparam int AW = $clog2(DEPTH);
  desc_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q, cnt_d;
  logic empty_q, drop_q, push;
  // full is judged on the registered count, so a same-cycle pop never frees a slot
  assign push = wr_i && cnt_q != (AW+1)'(DEPTH);
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop_i);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      empty_q <= 1'b1;
      drop_q <= 1'b0;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop_i) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_d;
      empty_q <= cnt_d == '0;
      drop_q <= wr_i && !push;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wp_q] <= din_i;
  assign head_o = mem_q[rp_q];
  assign empty_o = empty_q;
  assign drop_o = drop_q;
endmodule

// File: rtl/host_output_scheduler.sv
// host_output_scheduler: strict-priority TS>RC>BE descriptor issue to host_tx with BE anti-starvation
module host_output_scheduler
  import hos_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int BE_STARVE_MAX = 16
) (
  input logic i_clk,
  input logic i_rst_n,
  hos_if.slave bus
);
  localparam int SW = $clog2(BE_STARVE_MAX);
  hos_state_e state_q, state_d;
  desc_t desc_q, desc_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [2:0] wr, pop, empty, drop, gnt;
  desc_t din [3];
  desc_t head [3];
  logic be_force, fire;
  assign wr = {bus.i_be_descriptor_wr, bus.i_rc_descriptor_wr, bus.i_ts_descriptor_wr};
  assign din[TS] = bus.iv_ts_descriptor;
  assign din[RC] = bus.iv_rc_descriptor;
  assign din[BE] = bus.iv_be_descriptor;
  for (genvar c = 0; c < 3; c++) begin : g_q
    host_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(i_clk), .rst_n(i_rst_n), .wr_i(wr[c]), .din_i(din[c]), .pop_i(pop[c]),
      .head_o(head[c]), .empty_o(empty[c]), .drop_o(drop[c])
    );
  end
  assign be_force = !empty[BE] && starve_cnt_q == SW'(BE_STARVE_MAX - 1);
  assign gnt = be_force ? 3'b100 : !empty[TS] ? 3'b001 : !empty[RC] ? 3'b010 :
               !empty[BE] ? 3'b100 : 3'b000;
  assign fire = state_q == IDLE && bus.i_pkt_descriptor_ready && gnt != 3'b000;
  assign pop = fire ? gnt : 3'b000;
  assign desc_d = !fire ? desc_q : gnt[TS] ? head[TS] : gnt[RC] ? head[RC] : head[BE];
  // saturates so a held-off BE keeps its forced grant instead of wrapping to zero
  assign starve_cnt_d = (empty[BE] || pop[BE]) ? '0 :
                        ((pop[TS] || pop[RC]) && starve_cnt_q != SW'(BE_STARVE_MAX - 1)) ?
                        starve_cnt_q + SW'(1) : starve_cnt_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      desc_q <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      desc_q <= desc_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = fire ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = bus.i_pkt_descriptor_ready ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.o_pkt_descriptor_wr = state_q == ISSUE;
    bus.ov_pkt_descriptor = desc_q;
    bus.ov_overflow_pulse = drop;
    bus.ov_queue_empty = empty;
    bus.hos_state = state_q;
  end
endmodule

// File: tb/tb_host_output_scheduler.sv
// tb_host_output_scheduler: directed stimulus with a queue scoreboard checked on every issue strobe
module tb_host_output_scheduler;
  import hos_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  hos_if bus();
  host_output_scheduler dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int n_run = 0;
  int n_fail = 0;
  desc_t exp_q[$];
  desc_t ts_next;
  task automatic chk(string nm, int act, int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.o_pkt_descriptor_wr === 1'b1) begin
      n_run++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL issue_unexpected: got %0h expected none", bus.ov_pkt_descriptor);
      end else begin
        desc_t e;
        e = exp_q.pop_front();
        if (bus.ov_pkt_descriptor !== e) begin
          n_fail++;
          $display("FAIL issue_desc: got %0h expected %0h", bus.ov_pkt_descriptor, e);
        end
      end
    end
  end
  task automatic wr3(logic [2:0] m, desc_t t, desc_t r, desc_t b);
    bus.iv_ts_descriptor = t;
    bus.iv_rc_descriptor = r;
    bus.iv_be_descriptor = b;
    bus.i_ts_descriptor_wr = m[0];
    bus.i_rc_descriptor_wr = m[1];
    bus.i_be_descriptor_wr = m[2];
    @(negedge clk);
    bus.i_ts_descriptor_wr = 1'b0;
    bus.i_rc_descriptor_wr = 1'b0;
    bus.i_be_descriptor_wr = 1'b0;
  endtask
  task automatic wait_wr();
    int k = 0;
    while (bus.o_pkt_descriptor_wr !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("issue_seen", int'(bus.o_pkt_descriptor_wr), 1);
  endtask
  task automatic drain(int n, int refill);
    for (int i = 0; i < n; i++) begin
      bus.i_pkt_descriptor_ready = 1'b1;
      @(negedge clk);
      wait_wr();
      bus.i_pkt_descriptor_ready = 1'b0;
      @(negedge clk);
      if (i < refill) begin
        bus.iv_ts_descriptor = ts_next;
        bus.i_ts_descriptor_wr = 1'b1;
        ts_next = ts_next + 13'd1;
      end
      @(negedge clk);
      bus.i_ts_descriptor_wr = 1'b0;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    bus.iv_ts_descriptor = '0;
    bus.iv_rc_descriptor = '0;
    bus.iv_be_descriptor = '0;
    bus.i_ts_descriptor_wr = 1'b0;
    bus.i_rc_descriptor_wr = 1'b0;
    bus.i_be_descriptor_wr = 1'b0;
    bus.i_pkt_descriptor_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_desc", int'(bus.ov_pkt_descriptor), 0);
    chk("rst_wr", int'(bus.o_pkt_descriptor_wr), 0);
    chk("rst_ovf", int'(bus.ov_overflow_pulse), 0);
    chk("rst_empty", int'(bus.ov_queue_empty), 7);
    chk("rst_state", int'(bus.hos_state), 0);
    rst_n = 1'b1;
    @(negedge clk);
    // single BE descriptor and the full state walk
    exp_q.push_back(13'h0A5);
    wr3(3'b100, '0, '0, 13'h0A5);
    chk("t1_empty", int'(bus.ov_queue_empty), 3'b011);
    bus.i_pkt_descriptor_ready = 1'b1;
    @(negedge clk);
    chk("t1_issue_state", int'(bus.hos_state), 1);
    chk("t1_issue_wr", int'(bus.o_pkt_descriptor_wr), 1);
    @(negedge clk);
    chk("t1_wait_state", int'(bus.hos_state), 2);
    chk("t1_wait_wr", int'(bus.o_pkt_descriptor_wr), 0);
    @(negedge clk);
    chk("t1_wait_hold", int'(bus.hos_state), 2);
    bus.i_pkt_descriptor_ready = 1'b0;
    @(negedge clk);
    chk("t1_idle", int'(bus.hos_state), 0);
    // strict priority with all three classes written together
    exp_q.push_back(13'h101);
    exp_q.push_back(13'h202);
    exp_q.push_back(13'h303);
    wr3(3'b111, 13'h101, 13'h202, 13'h303);
    chk("t2_empty", int'(bus.ov_queue_empty), 0);
    drain(3, 0);
    chk("t2_drained", int'(bus.ov_queue_empty), 7);
    // TS overflow on the ninth write
    for (int i = 0; i < 9; i++) begin
      wr3(3'b001, 13'h010 + 13'(i), '0, '0);
      chk("t3_ovf", int'(bus.ov_overflow_pulse), (i == 8) ? 1 : 0);
    end
    @(negedge clk);
    chk("t3_ovf_clear", int'(bus.ov_overflow_pulse), 0);
    chk("t3_empty", int'(bus.ov_queue_empty), 3'b110);
    for (int i = 0; i < 8; i++) exp_q.push_back(13'h010 + 13'(i));
    drain(8, 0);
    chk("t3_drained", int'(bus.ov_queue_empty), 7);
    // BE anti-starvation under a TS queue kept busy
    wr3(3'b101, 13'h400, '0, 13'h3AA);
    for (int i = 1; i < 8; i++) wr3(3'b001, 13'h400 + 13'(i), '0, '0);
    ts_next = 13'h408;
    for (int i = 0; i < 15; i++) exp_q.push_back(13'h400 + 13'(i));
    exp_q.push_back(13'h3AA);
    for (int i = 15; i < 22; i++) exp_q.push_back(13'h400 + 13'(i));
    drain(15, 14);
    chk("t4_starve_max", int'(dut.starve_cnt_q), 15);
    drain(1, 0);
    chk("t4_starve_clr", int'(dut.starve_cnt_q), 0);
    drain(7, 0);
    chk("t4_drained", int'(bus.ov_queue_empty), 7);
    // ready stuck high: one issue only, then hold in WAIT
    exp_q.push_back(13'h055);
    exp_q.push_back(13'h066);
    bus.i_pkt_descriptor_ready = 1'b1;
    wr3(3'b001, 13'h055, '0, '0);
    chk("t5_not_yet", int'(bus.hos_state), 0);
    chk("t5_not_yet_wr", int'(bus.o_pkt_descriptor_wr), 0);
    @(negedge clk);
    chk("t5_issue", int'(bus.hos_state), 1);
    wr3(3'b001, 13'h066, '0, '0);
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_state", int'(bus.hos_state), 2);
      chk("t5_hold_wr", int'(bus.o_pkt_descriptor_wr), 0);
      @(negedge clk);
    end
    bus.i_pkt_descriptor_ready = 1'b0;
    @(negedge clk);
    chk("t5_idle", int'(bus.hos_state), 0);
    drain(1, 0);
    // reset during ISSUE discards the queued RC entries
    for (int i = 1; i < 5; i++) wr3(3'b010, '0, 13'h500 + 13'(i), '0);
    exp_q.push_back(13'h501);
    bus.i_pkt_descriptor_ready = 1'b1;
    @(negedge clk);
    wait_wr();
    rst_n = 1'b0;
    bus.i_pkt_descriptor_ready = 1'b0;
    @(negedge clk);
    chk("t6_wr", int'(bus.o_pkt_descriptor_wr), 0);
    chk("t6_state", int'(bus.hos_state), 0);
    chk("t6_empty", int'(bus.ov_queue_empty), 7);
    chk("t6_desc", int'(bus.ov_pkt_descriptor), 0);
    rst_n = 1'b1;
    bus.i_pkt_descriptor_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_quiet", int'(bus.hos_state), 0);
    end
    bus.i_pkt_descriptor_ready = 1'b0;
    @(negedge clk);
    chk("sb_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
